// File: rtl/ht_ltf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ht_ltf_seq_ctrl : boots the HT-LTF generator and streams 1/2/4 symbols
// Revision: 1.0
// ============================================================================
module ht_ltf_seq_ctrl #(
  parameter int BOOT_CYCLES = 340,
  parameter int SYM_LEN     = 80,
  parameter int COEFF_W     = 128
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         num_ltf,
  input  logic [COEFF_W-1:0] coeff_in,
  output logic               gen_reset,
  output logic               gen_boot,
  output logic               gen_output_enabled,
  output logic [COEFF_W-1:0] gen_obf_coeff,
  input  logic [31:0]        gen_sample,
  output logic [31:0]        out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int WAIT_W = $clog2(BOOT_CYCLES + 1);
  localparam int SMP_W  = $clog2(SYM_LEN);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GRST   = 3'd1;
  localparam logic [2:0] S_BOOT   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;
  localparam logic [2:0] S_ABRT   = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SMP_W-1:0]  smp_cnt;
  logic [1:0]        sym_cnt;
  logic [2:0]        num_reg;
  logic              num_legal;
  logic              accept;
  logic              abort_hit;
  logic              xfer;
  logic              smp_wrap;
  logic              last_sym;

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction

  assign num_legal = (num_ltf == 3'd1) || (num_ltf == 3'd2) || (num_ltf == 3'd4);
  assign accept    = (state == S_IDLE) && start && num_legal;
  assign abort_hit = abort && (state != S_IDLE);
  assign xfer      = (state == S_STREAM) && out_ready;
  assign smp_wrap  = (smp_cnt == SMP_W'(SYM_LEN - 1));
  assign last_sym  = ({1'b0, sym_cnt} == (num_reg - 3'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_GRST;
      S_GRST:   state_nxt = S_BOOT;
      S_BOOT:   state_nxt = S_WAIT;
      S_WAIT:   if (wait_cnt == WAIT_W'(BOOT_CYCLES - 1)) state_nxt = S_STREAM;
      S_STREAM: if (xfer && smp_wrap && last_sym) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      S_ABRT:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_ABRT;
  end

  always_comb begin
    gen_reset          = (state == S_GRST) || (state == S_ABRT);
    gen_boot           = (state == S_BOOT);
    out_valid          = (state == S_STREAM);
    gen_output_enabled = (state == S_STREAM) && out_ready;
    out_last           = (state == S_STREAM) && smp_wrap && last_sym;
    busy               = (state != S_IDLE);
    done               = (state == S_FIN);
    out_sample         = 32'd0;
    if (state == S_STREAM) begin
      // P-matrix row 0 is (+1, -1, +1, +1): only the second symbol flips
      out_sample = (sym_cnt == 2'd1) ? {neg_sat(gen_sample[31:16]), neg_sat(gen_sample[15:0])}
                                     : gen_sample;
    end
  end

  // Wait count runs from the boot pulse so STREAM opens BOOT_CYCLES after it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      smp_cnt  <= '0;
      sym_cnt  <= '0;
    end else if (abort_hit) begin
      wait_cnt <= '0;
      smp_cnt  <= '0;
      sym_cnt  <= '0;
    end else begin
      if ((state == S_BOOT) || (state == S_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state != S_STREAM) begin
        smp_cnt <= '0;
        sym_cnt <= '0;
      end else if (xfer) begin
        if (smp_wrap) begin
          smp_cnt <= '0;
          sym_cnt <= sym_cnt + 2'd1;
        end else begin
          smp_cnt <= smp_cnt + SMP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_obf_coeff <= '0;
      num_reg       <= '0;
      error         <= 1'b0;
    end else begin
      error <= (state == S_IDLE) && start && !num_legal;
      if (accept) begin
        gen_obf_coeff <= coeff_in;
        num_reg       <= num_ltf;
      end
    end
  end

endmodule
`default_nettype wire
